// File: rtl/imem_loader.sv
// imem_loader: boot loader that turns a length-prefixed UART byte stream into instruction-memory word writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte before completion.
module imem_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_start,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  rx_ready,
   output logic                  mem_en,
   output logic                  mem_write_en,
   output logic [31:0]           mem_addr,
   output logic [31:0]           mem_write_data,
   output logic                  cpu_hold,
   output logic                  load_done,
   output logic                  load_error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM   = 3'd4,
`endif
      S_ERR    = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            len_lo_q, len_lo_d;
   logic [15:0]           len_q, len_d;
   logic [1:0]            byte_idx_q, byte_idx_d;
   logic [23:0]           word_q, word_d;
   logic [ADDR_WIDTH:0]   words_q, words_d;
   logic                  mem_en_q, mem_en_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]           mem_data_q, mem_data_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [15:0]           len_rx;
   logic                  data_acc;

   assign len_rx = {rx_data, len_lo_q};

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] sum_q, sum_d;
   logic [7:0] csum_chk;
   logic       last_word;

   assign csum_chk  = sum_q + rx_data;
   assign last_word = (32'(words_q) + 32'd1) == 32'(len_q);
   assign data_acc  = (state_q == S_DATA) && rx_valid;
`else
   logic all_written;

   // Once the final word is written, the exit cycle ignores any further bytes.
   assign all_written = 32'(words_q) == 32'(len_q);
   assign data_acc    = (state_q == S_DATA) && rx_valid && !all_written;
`endif

   always_comb begin
      state_d    = state_q;
      len_lo_d   = len_lo_q;
      len_d      = len_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      words_d    = words_q;
      mem_en_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      done_d     = 1'b0;
      err_d      = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d      = sum_q;
`endif

      case (state_q)
         S_IDLE: begin
         end
         S_LEN_LO: begin
            if (rx_valid) begin
               len_lo_d = rx_data;
               state_d  = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (rx_valid) begin
               len_d = len_rx;
               if ({16'd0, len_rx} > DEPTH) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end else if (len_rx == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_d = S_CSUM;
`else
                  state_d = S_IDLE;
                  done_d  = 1'b1;
`endif
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (data_acc && (byte_idx_q == 2'd3) && last_word) begin
               state_d = S_CSUM;
            end
`else
            if (all_written) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
`endif
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (rx_valid) begin
               if (csum_chk == 8'd0) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end
            end
         end
`endif
         S_ERR: begin
         end
         default: state_d = S_IDLE;
      endcase

      // Bytes 0..2 shift in from the top so the fourth byte completes {b3,b2,b1,b0}.
      if (data_acc) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_d = csum_chk;
`endif
         if (byte_idx_q == 2'd3) begin
            mem_en_d   = 1'b1;
            mem_addr_d = words_q[ADDR_WIDTH-1:0];
            mem_data_d = {rx_data, word_q};
            words_d    = words_q + 1'b1;
            byte_idx_d = 2'd0;
         end else begin
            word_d     = {rx_data, word_q[23:8]};
            byte_idx_d = byte_idx_q + 2'd1;
         end
      end

      // Restart overrides everything, including a byte accepted this same cycle.
      if (load_start) begin
         state_d    = S_LEN_LO;
         err_d      = 1'b0;
         words_d    = '0;
         byte_idx_d = 2'd0;
         word_d     = 24'd0;
         mem_en_d   = 1'b0;
         done_d     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_d      = 8'd0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         len_lo_q   <= 8'd0;
         len_q      <= 16'd0;
         byte_idx_q <= 2'd0;
         word_q     <= 24'd0;
         words_q    <= '0;
         mem_en_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= 32'd0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q      <= 8'd0;
`endif
      end else begin
         state_q    <= state_d;
         len_lo_q   <= len_lo_d;
         len_q      <= len_d;
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
         words_q    <= words_d;
         mem_en_q   <= mem_en_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         done_q     <= done_d;
         err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q      <= sum_d;
`endif
      end
   end

   assign rx_ready       = (state_q != S_IDLE) && (state_q != S_ERR);
   assign cpu_hold       = (state_q != S_IDLE);
   assign mem_en         = mem_en_q;
   assign mem_write_en   = mem_en_q;
   assign mem_addr       = {{(32-ADDR_WIDTH){1'b0}}, mem_addr_q};
   assign mem_write_data = mem_data_q;
   assign load_done      = done_q;
   assign load_error     = err_q;
   assign words_loaded   = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random byte streams checked against a stream-level model of the expected writes.
module tb_imem_loader;

   typedef logic [7:0] bq_t[$];

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_start = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_ready;
   logic        mem_en;
   logic        mem_write_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic        cpu_hold;
   logic        load_done;
   logic        load_error;
   logic [10:0] words_loaded;

   imem_loader #(.ADDR_WIDTH(10), .DEPTH(1024)) dut (
      .clk            (clk),
      .rst            (rst),
      .load_start     (load_start),
      .rx_valid       (rx_valid),
      .rx_data        (rx_data),
      .rx_ready       (rx_ready),
      .mem_en         (mem_en),
      .mem_write_en   (mem_write_en),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .cpu_hold       (cpu_hold),
      .load_done      (load_done),
      .load_error     (load_error),
      .words_loaded   (words_loaded)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   bq_t stim;
   bq_t pre;
   logic [31:0] got_addr[$];
   logic [31:0] got_data[$];
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   int exp_n, exp_err, exp_done, exp_ovf;
   int done_cnt, viol, cyc, last_wr_cyc, done_cyc;
   bit prev_en;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bus monitor: records write strobes, load_done pulses and protocol violations.
   always @(negedge clk) begin
      cyc++;
      if (mem_en) begin
         got_addr.push_back(mem_addr);
         got_data.push_back(mem_write_data);
         last_wr_cyc = cyc;
         if (prev_en || mem_write_en !== 1'b1) viol++;
      end else if (mem_write_en) begin
         viol++;
      end
      prev_en = mem_en;
      if (load_done) begin
         done_cnt++;
         done_cyc = cyc;
         if (cpu_hold) viol++;
      end
   end

   task automatic check_reset(input string tag);
      check_eq({tag, ":rx_ready"}, rx_ready, 0);
      check_eq({tag, ":mem_en"}, {mem_en, mem_write_en}, 0);
      check_eq({tag, ":mem_addr"}, mem_addr, 0);
      check_eq({tag, ":mem_data"}, mem_write_data, 0);
      check_eq({tag, ":cpu_hold"}, cpu_hold, 0);
      check_eq({tag, ":load_done"}, load_done, 0);
      check_eq({tag, ":load_error"}, load_error, 0);
      check_eq({tag, ":words"}, words_loaded, 0);
   endtask

   task automatic add_csum(input bit good);
      logic [7:0] sum;
      logic [7:0] c;
      sum = 8'd0;
      for (int i = 2; i < stim.size(); i++) sum = sum + stim[i];
      c = good ? (8'd0 - sum) : (8'd1 - sum);
`ifdef IMEM_LOADER_CHECKSUM_EN
      stim.push_back(c);
`endif
   endtask

   // Expected outcome of a load, derived directly from the stream format.
   task automatic model();
      int b;
      int sum;
      exp_addr.delete();
      exp_data.delete();
      exp_n   = int'(stim[0]) + 256 * int'(stim[1]);
      exp_ovf = (exp_n > 1024) ? 1 : 0;
      if (exp_ovf != 0) begin
         exp_err = 1; exp_done = 0; exp_n = 0;
         return;
      end
      for (int k = 0; k < exp_n; k++) begin
         b = 2 + 4 * k;
         exp_addr.push_back(32'(k));
         exp_data.push_back({stim[b+3], stim[b+2], stim[b+1], stim[b]});
      end
      exp_err = 0; exp_done = 1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum = 0;
      for (int i = 2; i <= 2 + 4 * exp_n; i++) sum += int'(stim[i]);
      if (sum % 256 != 0) begin
         exp_err = 1; exp_done = 0;
      end
`else
      sum = 0;
`endif
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int w;
      w = 0;
      repeat (gap) @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!rx_ready) check_eq("rdy_timeout", rx_ready, 1);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic start_load(input bit with_byte);
      load_start = 1'b1;
      if (with_byte) begin
         rx_valid = 1'b1;
         rx_data  = 8'hAA;
      end
      @(negedge clk);
      load_start = 1'b0;
      rx_valid   = 1'b0;
   endtask

   task automatic run_load(input string tag, input int gapmax);
      int nsend;
      int nc;
      model();
      got_addr.delete();
      got_data.delete();
      done_cnt = 0;
      viol     = 0;
      start_load(1'b0);
      check_eq({tag, ":busy"}, {cpu_hold, rx_ready, load_error}, 3'b110);
      if (pre.size() > 0) begin
         foreach (pre[i]) send_byte(pre[i], 0);
         start_load(1'b1);
         check_eq({tag, ":restart"}, {cpu_hold, rx_ready, load_error, words_loaded}, {3'b110, 11'd0});
      end
      nsend = (exp_ovf != 0) ? 2 : stim.size();
      for (int i = 0; i < nsend; i++) send_byte(stim[i], $urandom_range(0, gapmax));
      repeat (4) @(negedge clk);
      check_eq({tag, ":nwrites"}, got_addr.size(), exp_addr.size());
      nc = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
      for (int i = 0; i < nc; i++) begin
         check_eq({tag, ":addr"}, got_addr[i], exp_addr[i]);
         check_eq({tag, ":data"}, got_data[i], exp_data[i]);
      end
      check_eq({tag, ":done_pulses"}, done_cnt, exp_done);
      check_eq({tag, ":load_error"}, load_error, exp_err);
      check_eq({tag, ":words"}, words_loaded, exp_n);
      check_eq({tag, ":cpu_hold"}, cpu_hold, exp_err);
      check_eq({tag, ":rx_ready"}, rx_ready, 0);
      check_eq({tag, ":protocol"}, viol, 0);
`ifndef IMEM_LOADER_CHECKSUM_EN
      if (exp_n > 0 && exp_done != 0) check_eq({tag, ":done_lat"}, done_cyc, last_wr_cyc + 1);
`endif
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      @(negedge clk);
      check_reset("idle");

      stim = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      add_csum(1'b1);
      run_load("normal", 0);

      stim = '{8'h00, 8'h00};
      add_csum(1'b1);
      run_load("zero", 0);

      stim = '{8'h01, 8'h04};
      run_load("ovf", 0);

      stim = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      add_csum(1'b1);
      run_load("gapped", 7);

      pre  = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34};
      stim = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
      add_csum(1'b1);
      run_load("restart", 2);
      pre.delete();

      stim = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      add_csum(1'b1);
      run_load("csum_good", 1);
      stim = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      add_csum(1'b0);
      run_load("csum_bad", 1);

      stim = '{8'h00, 8'h04};
      for (int j = 0; j < 4096; j++) stim.push_back(8'($urandom));
      add_csum(1'b1);
      run_load("full_depth", 0);

      for (int it = 0; it < 10; it++) begin
         n = $urandom_range(0, 6);
         stim.delete();
         stim.push_back(8'(n));
         stim.push_back(8'h00);
         for (int j = 0; j < 4 * n; j++) stim.push_back(8'($urandom));
         add_csum($urandom_range(0, 3) != 0);
         run_load("rand", $urandom_range(0, 7));
      end

      stim = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      start_load(1'b0);
      foreach (stim[i]) send_byte(stim[i], 0);
      check_eq("midrst:strobe", {mem_en, mem_write_data}, {1'b1, 32'h44332211});
      rst      = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h55;
      @(negedge clk);
      rx_valid = 1'b0;
      check_reset("midrst");
      rst = 1'b0;
      @(negedge clk);
      check_reset("post_rst");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time program loader and write-side master for the instruction memory's write port. Accepts a length-prefixed byte stream from the UART receiver and assembles little-endian 32-bit words. Writes them to consecutive word addresses starting at 0 and holds the CPU in reset while loading. Signals completion or error to the top level.

Parameters:
ADDR_WIDTH, 10, word-address width of the target memory
DEPTH, 1024, memory depth in words; must equal 2**ADDR_WIDTH

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-high reset
load_start  in  1  one-cycle pulse; begins or restarts a load
rx_valid  in  1  byte available from UART receiver
rx_data  in  8  received byte
rx_ready  out  1  loader accepts byte; transfer occurs when rx_valid && rx_ready
mem_en  out  1  write-port enable
mem_write_en  out  1  write-port write enable
mem_addr  out  32  word index in [ADDR_WIDTH-1:0]; upper bits always 0
mem_write_data  out  32  assembled word
cpu_hold  out  1  holds CPU in reset while loading
load_done  out  1  one-cycle pulse on successful completion
load_error  out  1  sticky error flag; cleared by load_start or rst
words_loaded  out  ADDR_WIDTH+1  count of words written in the current load

Behaviour:
- Reset values: rx_ready=0, mem_en=0, mem_write_en=0, mem_addr=0, mem_write_data=0, cpu_hold=0, load_done=0, load_error=0, words_loaded=0, state=IDLE.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes. Byte 0 of each word maps to bits [7:0] and byte 3 to bits [31:24].
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM (feature only), ERR.
- IDLE: rx_ready=0, cpu_hold=0.
  - load_start -> LEN_LO; clear load_error, words_loaded, byte index.
- LEN_LO, LEN_HI, DATA, CSUM: rx_ready=1 continuously, with no backpressure. A full word needs 4 bytes, so one write per word never stalls. cpu_hold=1 in all four states.
- LEN_LO: accepted byte -> N[7:0]; go to LEN_HI.
- LEN_HI: accepted byte -> N[15:8], then evaluate N:
  - N > DEPTH: go to ERR, set load_error; no writes.
  - N == 0: go to IDLE (or CSUM); pulse load_done the next cycle.
  - Otherwise: go to DATA.
- DATA write timing: on the cycle the 4th byte of word k is accepted, the next edge drives mem_en=1, mem_write_en=1, mem_addr=k, mem_write_data={b3,b2,b1,b0} for exactly one cycle. words_loaded increments on that same edge.
- DATA exit: when words_loaded reaches N, the cycle after the final write strobe pulses load_done and deasserts cpu_hold. State returns to IDLE (or CSUM if the feature is enabled).
- rx_valid gaps: stall progress only; partial-word bytes are retained indefinitely.
- ERR: rx_ready=0, cpu_hold=1, load_error=1. Stays in ERR until load_start (restart) or rst.
- load_start in any non-IDLE state: restart at LEN_LO, clear counters and load_error. A pending write strobe in the same cycle still completes.
- load_start in the same cycle as a byte acceptance: restart wins and the byte is discarded.
- rst mid-load: immediate return to reset values. Memory contents already written are not rolled back.
- mem_en and mem_write_en are always equal; the loader never issues reads.
- Wrap-around: addresses never wrap. N ≤ DEPTH is guaranteed by the LEN_HI check, so the highest address written is DEPTH-1.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum of all data bytes accumulates mod 256 (length bytes excluded).
  - After the last data word (or immediately when N==0), go to CSUM and accept one byte C.
  - If (sum + C) mod 256 == 0: pulse load_done, deassert cpu_hold, go to IDLE.
  - Otherwise: go to ERR with load_error=1.
  - load_done is deferred until the checksum byte is accepted.
- Undefined: no CSUM state and no accumulator. Completion occurs right after the final write, as described above.

Test Plan:
1. Normal load: load_start; bytes 02 00 78 56 34 12 EF BE AD DE -> writes addr0=0x12345678, addr1=0xDEADBEEF, each strobe one cycle; load_done pulse; words_loaded=2; cpu_hold back to 0.
2. Zero length: bytes 00 00 -> no mem_en; load_done pulse; load_error=0.
3. Overflow: bytes 01 04 (N=1025) -> no writes; load_error=1; rx_ready=0; next load_start clears load_error.
4. Gapped stream: same bytes as test 1 with 0-7 idle cycles between rx_valid pulses -> identical writes and data; no spurious strobes.
5. Restart: load_start after 5 bytes of test 1, then a fresh stream 01 00 44 33 22 11 -> single write addr0=0x11223344; words_loaded=1.
6. Checksum (IMEM_LOADER_CHECKSUM_EN): stream 01 00 01 02 03 04 F6 -> load_done. Same stream with checksum byte F7 -> load_error=1, no load_done. rst during DATA -> all outputs return to reset values next cycle.
